// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter: MSB-first bit stream, 1 bit/clk, with a comma
// alignment prelude after reset and comma fill whenever no valid data is offered.
module paralelo_serial #(
    parameter logic [7:0] COMMA     = 8'hBC,
    parameter int         NUM_COMMA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Entrada,
    input  logic       validEntrada,
    output logic       Salida,
    output logic       load,
    output logic       activo
);

    // state    | meaning
    // ST_RESET | held in reset, nothing transmitted
    // ST_COMMA | sending the post-reset comma prelude
    // ST_RUN   | data path open, Entrada sampled at each byte boundary
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_COMMA = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int CW = (NUM_COMMA < 2) ? 1 : $clog2(NUM_COMMA + 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      sr_q, sr_d;
    logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
    logic            salida_q, salida_d;

    logic            boundary;
    logic            comma_done;
    logic            take_data;
    logic [7:0]      next_byte;
    logic [7:0]      sr_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            cnt_q       <= 3'd7;
            sr_q        <= 8'h00;
            comma_cnt_q <= '0;
            salida_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            comma_cnt_q <= comma_cnt_d;
            salida_q    <= salida_d;
        end
    end

    assign boundary   = (cnt_q == 3'd7);
    assign comma_done = (comma_cnt_q == CW'(NUM_COMMA));
    // The last comma boundary already samples Entrada, so RUN data starts with no gap.
    assign take_data  = (state_q == ST_RUN) || ((state_q == ST_COMMA) && comma_done);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_COMMA;
            ST_COMMA: if (boundary && comma_done) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        comma_cnt_d = comma_cnt_q;
        if (state_q == ST_RESET) begin
            comma_cnt_d = CW'(1);
        end else if ((state_q == ST_COMMA) && boundary && !comma_done) begin
            comma_cnt_d = comma_cnt_q + CW'(1);
        end
    end

    always_comb begin
        next_byte = COMMA;
        if (take_data && validEntrada) next_byte = Entrada;
        sr_shift = sr_q << 1;
        if (boundary) begin
            cnt_d    = 3'd0;
            sr_d     = next_byte;
            salida_d = next_byte[7];
        end else begin
            cnt_d    = cnt_q + 3'd1;
            sr_d     = sr_shift;
            salida_d = sr_shift[7];
        end
    end

    always_comb begin
        load   = boundary && take_data;
        activo = (state_q == ST_RUN);
    end

    assign Salida = salida_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: comma prelude, table of data bytes,
// non-boundary input changes and reset in the middle of a byte.
module tb_paralelo_serial;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk;
    logic       reset;
    logic [7:0] Entrada;
    logic       validEntrada;
    logic       Salida;
    logic       load;
    logic       activo;

    int checks;
    int failures;

    paralelo_serial #(.COMMA(COMMA), .NUM_COMMA(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
        .Salida       (Salida),
        .load         (load),
        .activo       (activo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_commas(input string tag);
        logic [7:0] got;
        int         lerr;
        int         aerr;
        for (int b = 0; b < 4; b++) begin
            got  = 8'h00;
            lerr = 0;
            aerr = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                got = {got[6:0], Salida};
                if (!((b == 3) && (i == 7)) && load) lerr++;
                if (activo) aerr++;
            end
            check($sformatf("%s_comma%0d_byte", tag, b), {24'h0, got}, {24'h0, COMMA});
            check($sformatf("%s_comma%0d_load_low", tag, b), lerr, 0);
            check($sformatf("%s_comma%0d_activo_low", tag, b), aerr, 0);
        end
        check({tag, "_first_load"}, {31'h0, load}, 32'h1);
    endtask

    // Called with the bench sitting just before a load edge.
    task automatic send_byte(input string tag, input logic [7:0] d, input logic v,
                             input logic [7:0] exp);
        logic [7:0] got;
        int         lerr;
        got  = 8'h00;
        lerr = 0;
        Entrada      = d;
        validEntrada = v;
        for (int i = 0; i < 8; i++) begin
            tick();
            got = {got[6:0], Salida};
            if (i == 0) begin
                check({tag, "_activo"}, {31'h0, activo}, 32'h1);
                Entrada      = ~d;
                validEntrada = ~v;
            end
            if ((i < 7) && load) lerr++;
        end
        check({tag, "_byte"}, {24'h0, got}, {24'h0, exp});
        check({tag, "_load_gap"}, lerr, 0);
        check({tag, "_next_load"}, {31'h0, load}, 32'h1);
    endtask

    initial begin
        logic [2:0] part;
        checks   = 0;
        failures = 0;

        vecs[0] = '{din: 8'hA5, vld: 1'b1, exp: 8'hA5};
        vecs[1] = '{din: 8'hFF, vld: 1'b0, exp: 8'hBC};
        vecs[2] = '{din: 8'h00, vld: 1'b1, exp: 8'h00};
        vecs[3] = '{din: 8'hFF, vld: 1'b1, exp: 8'hFF};
        vecs[4] = '{din: 8'h3C, vld: 1'b1, exp: 8'h3C};
        vecs[5] = '{din: 8'h81, vld: 1'b0, exp: 8'hBC};
        vecs[6] = '{din: 8'h5A, vld: 1'b1, exp: 8'h5A};

        reset        = 1'b1;
        Entrada      = 8'h00;
        validEntrada = 1'b0;
        tick();
        tick();
        check("rst_salida", {31'h0, Salida}, 32'h0);
        check("rst_load",   {31'h0, load},   32'h0);
        check("rst_activo", {31'h0, activo}, 32'h0);

        reset = 1'b0;
        run_commas("boot");
        check("boot_activo_before_run", {31'h0, activo}, 32'h0);

        for (int k = 0; k < 7; k++) begin
            send_byte($sformatf("vec%0d", k), vecs[k].din, vecs[k].vld, vecs[k].exp);
        end

        // Abort a byte three bits in; C3 starts 1,1,0.
        Entrada      = 8'hC3;
        validEntrada = 1'b1;
        part = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            part = {part[1:0], Salida};
        end
        check("abort_partial_bits", {29'h0, part}, {29'h0, 3'b110});
        reset = 1'b1;
        tick();
        check("abort_salida", {31'h0, Salida}, 32'h0);
        check("abort_load",   {31'h0, load},   32'h0);
        check("abort_activo", {31'h0, activo}, 32'h0);
        tick();
        check("abort_hold_salida", {31'h0, Salida}, 32'h0);

        reset        = 1'b0;
        Entrada      = 8'hFF;
        validEntrada = 1'b1;
        run_commas("rerun");
        send_byte("after_reset", 8'h66, 1'b1, 8'h66);
        send_byte("after_reset_idle", 8'h12, 1'b0, COMMA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
